// File: rtl/icache_array_arbiter.sv
// Arbitrates the data-array SRAM port between lookup reads and 4-beat block writes.
// Writes own the port for a whole block; a starvation counter lets a read in between blocks.
module icache_array_arbiter #(
  parameter int unsigned SET_BITS_WIDTH = 4,
  parameter int unsigned NUM_WAYS       = 4,
  parameter int unsigned DA_WRITE_WIDTH = 80,
  parameter int unsigned DA_BEATS       = 4,
  parameter int unsigned STARVE_LIMIT   = 3,
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS),
  localparam int unsigned BEAT_W   = $clog2(DA_BEATS),
  localparam int unsigned ADDR_W   = SET_BITS_WIDTH + WAY_W + BEAT_W
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      i_rd_valid,
  input  logic [SET_BITS_WIDTH-1:0] i_rd_set,
  input  logic [WAY_W-1:0]          i_rd_way,
  input  logic [BEAT_W-1:0]         i_rd_word,
  output logic                      o_rd_ready,
  input  logic                      i_wr_valid,
  input  logic [SET_BITS_WIDTH-1:0] i_wr_set,
  input  logic [WAY_W-1:0]          i_wr_way,
  input  logic [DA_WRITE_WIDTH-1:0] i_wr_data,
  output logic                      o_wr_ready,
  output logic                      o_wr_done,
  input  logic                      i_da_halt,
  output logic                      o_da_valid,
  output logic                      o_da_we,
  output logic [ADDR_W-1:0]         o_da_addr,
  output logic [DA_WRITE_WIDTH-1:0] o_da_wdata,
  output logic                      o_busy
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  localparam logic ST_IDLE     = 1'b0;
  localparam logic ST_WR_BURST = 1'b1;

  logic                      r_state;
  logic [BEAT_W-1:0]         r_beat;
  logic [STARVE_W-1:0]       r_starve;
  logic [SET_BITS_WIDTH-1:0] r_set;
  logic [WAY_W-1:0]          r_way;
  logic                      r_wr_done;
  logic                      r_da_valid;
  logic                      r_da_we;
  logic [ADDR_W-1:0]         r_da_addr;
  logic [DA_WRITE_WIDTH-1:0] r_da_wdata;

  logic                      w_idle;
  logic                      w_starved;
  logic                      w_rd_grant;
  logic                      w_wr_grant;
  logic                      w_rd_xfer;
  logic                      w_wr_xfer;
  logic                      w_wr_last;
  logic [BEAT_W-1:0]         w_wr_beat;
  logic [SET_BITS_WIDTH-1:0] w_wr_set;
  logic [WAY_W-1:0]          w_wr_way;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_starved  = (r_starve == STARVE_W'(STARVE_LIMIT));
  // Reads only ever win in IDLE, so a block in flight can never be interleaved with a read.
  assign w_rd_grant = w_idle & i_rd_valid & (~i_wr_valid | w_starved);
  assign w_wr_grant = i_wr_valid & ~w_rd_grant;

  // Readies are forced low while reset is asserted.
  assign w_rd_xfer  = w_rd_grant & ~i_da_halt & arst_n;
  assign w_wr_xfer  = w_wr_grant & ~i_da_halt & arst_n;

  assign w_wr_beat  = w_idle ? '0 : r_beat;
  assign w_wr_set   = w_idle ? i_wr_set : r_set;
  assign w_wr_way   = w_idle ? i_wr_way : r_way;
  assign w_wr_last  = w_wr_xfer & (w_wr_beat == BEAT_W'(DA_BEATS - 1));

  assign o_rd_ready = w_rd_xfer;
  assign o_wr_ready = w_wr_xfer;
  assign o_wr_done  = r_wr_done;
  assign o_busy     = (r_state == ST_WR_BURST);
  assign o_da_valid = r_da_valid;
  assign o_da_we    = r_da_we;
  assign o_da_addr  = r_da_addr;
  assign o_da_wdata = r_da_wdata;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= ST_IDLE;
      r_beat     <= '0;
      r_starve   <= '0;
      r_set      <= '0;
      r_way      <= '0;
      r_wr_done  <= 1'b0;
      r_da_valid <= 1'b0;
      r_da_we    <= 1'b0;
      r_da_addr  <= '0;
      r_da_wdata <= '0;
    end else begin
      r_wr_done <= w_wr_last;

      if (w_rd_xfer) begin
        r_starve <= '0;
      end else if (i_rd_valid && !w_starved) begin
        r_starve <= r_starve + 1'b1;
      end

      if (w_wr_xfer) begin
        if (w_wr_last) begin
          r_state <= ST_IDLE;
          r_beat  <= '0;
        end else begin
          r_state <= ST_WR_BURST;
          r_beat  <= w_wr_beat + 1'b1;
        end
        if (w_idle) begin
          r_set <= i_wr_set;
          r_way <= i_wr_way;
        end
      end

      // A halted port keeps the whole command, valid included, until it can take it.
      if (!i_da_halt) begin
        r_da_valid <= w_rd_xfer | w_wr_xfer;
        if (w_wr_xfer) begin
          r_da_we    <= 1'b1;
          r_da_addr  <= {w_wr_set, w_wr_way, w_wr_beat};
          r_da_wdata <= i_wr_data;
        end else if (w_rd_xfer) begin
          r_da_we    <= 1'b0;
          r_da_addr  <= {i_rd_set, i_rd_way, i_rd_word};
          r_da_wdata <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_array_arbiter.sv
// Directed bench for icache_array_arbiter with a per-cycle reference model and literal spot checks.
module tb_icache_array_arbiter;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        i_rd_valid;
  logic [3:0]  i_rd_set;
  logic [1:0]  i_rd_way;
  logic [1:0]  i_rd_word;
  logic        o_rd_ready;
  logic        i_wr_valid;
  logic [3:0]  i_wr_set;
  logic [1:0]  i_wr_way;
  logic [79:0] i_wr_data;
  logic        o_wr_ready;
  logic        o_wr_done;
  logic        i_da_halt;
  logic        o_da_valid;
  logic        o_da_we;
  logic [7:0]  o_da_addr;
  logic [79:0] o_da_wdata;
  logic        o_busy;

  localparam int STARVE_LIMIT = 3;

  icache_array_arbiter #(
    .SET_BITS_WIDTH(4),
    .NUM_WAYS(4),
    .DA_WRITE_WIDTH(80),
    .DA_BEATS(4),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .i_rd_valid(i_rd_valid), .i_rd_set(i_rd_set), .i_rd_way(i_rd_way), .i_rd_word(i_rd_word),
    .o_rd_ready(o_rd_ready),
    .i_wr_valid(i_wr_valid), .i_wr_set(i_wr_set), .i_wr_way(i_wr_way), .i_wr_data(i_wr_data),
    .o_wr_ready(o_wr_ready), .o_wr_done(o_wr_done),
    .i_da_halt(i_da_halt),
    .o_da_valid(o_da_valid), .o_da_we(o_da_we), .o_da_addr(o_da_addr), .o_da_wdata(o_da_wdata),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: block progress as a beat count, starvation as a plain integer.
  bit          m_blk = 0;
  int          m_beat = 0;
  int          m_starve = 0;
  logic [3:0]  m_set = '0;
  logic [1:0]  m_way = '0;
  bit          e_valid = 0;
  bit          e_we = 0;
  bit          e_done = 0;
  logic [7:0]  e_addr = '0;
  logic [79:0] e_wdata = '0;

  initial forever begin
    bit rd_win, wr_win, rr, wr;
    int b;
    logic [3:0] s;
    logic [1:0] w;
    @(negedge clk);
    if (!arst_n) begin
      chk("m_rst_valid", o_da_valid, 0);
      chk("m_rst_we", o_da_we, 0);
      chk("m_rst_addr", o_da_addr, 0);
      chk("m_rst_wdata", o_da_wdata, 0);
      chk("m_rst_done", o_wr_done, 0);
      chk("m_rst_busy", o_busy, 0);
      chk("m_rst_rd_ready", o_rd_ready, 0);
      chk("m_rst_wr_ready", o_wr_ready, 0);
      m_blk = 0; m_beat = 0; m_starve = 0; m_set = '0; m_way = '0;
      e_valid = 0; e_we = 0; e_done = 0; e_addr = '0; e_wdata = '0;
    end else begin
      chk("m_valid", o_da_valid, e_valid);
      if (e_valid) begin
        chk("m_we", o_da_we, e_we);
        chk("m_addr", o_da_addr, e_addr);
        chk("m_wdata", o_da_wdata, e_wdata);
      end
      chk("m_done", o_wr_done, e_done);
      chk("m_busy", o_busy, m_blk);

      rd_win = !m_blk && i_rd_valid && (!i_wr_valid || m_starve == STARVE_LIMIT);
      wr_win = i_wr_valid && !rd_win;
      rr = rd_win && !i_da_halt;
      wr = wr_win && !i_da_halt;
      chk("m_rd_ready", o_rd_ready, rr);
      chk("m_wr_ready", o_wr_ready, wr);

      e_done = 0;
      if (!i_da_halt) begin
        e_valid = rr || wr;
        if (wr) begin
          b = m_blk ? m_beat : 0;
          s = m_blk ? m_set : i_wr_set;
          w = m_blk ? m_way : i_wr_way;
          e_we = 1;
          e_addr = {s, w, 2'(b)};
          e_wdata = i_wr_data;
          if (b == 3) begin
            e_done = 1; m_blk = 0; m_beat = 0;
          end else begin
            m_blk = 1; m_beat = b + 1; m_set = s; m_way = w;
          end
        end else if (rr) begin
          e_we = 0;
          e_addr = {i_rd_set, i_rd_way, i_rd_word};
          e_wdata = '0;
        end
      end
      if (rr) m_starve = 0;
      else if (i_rd_valid && m_starve < STARVE_LIMIT) m_starve++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rd_cyc;
    int ndone;
    arst_n = 1'b0;
    i_rd_valid = 0; i_rd_set = '0; i_rd_way = '0; i_rd_word = '0;
    i_wr_valid = 0; i_wr_set = '0; i_wr_way = '0; i_wr_data = '0;
    i_da_halt = 0;
    repeat (3) step();
    i_rd_valid = 1; i_wr_valid = 1;
    #1;
    chk("rst_rd_ready", o_rd_ready, 0);
    chk("rst_wr_ready", o_wr_ready, 0);
    chk("rst_valid", o_da_valid, 0);
    i_rd_valid = 0; i_wr_valid = 0;
    step();
    arst_n = 1'b1;

    // Single read
    i_rd_valid = 1; i_rd_set = 4'd5; i_rd_way = 2'd2; i_rd_word = 2'd1;
    #1;
    chk("t1_rd_ready", o_rd_ready, 1);
    step();
    i_rd_valid = 0;
    chk("t1_valid", o_da_valid, 1);
    chk("t1_we", o_da_we, 0);
    chk("t1_addr", o_da_addr, 8'h59);
    step();
    chk("t1_idle_valid", o_da_valid, 0);

    // Uncontended block write; set/way inputs change after beat 0 to prove latching
    i_wr_valid = 1; i_wr_set = 4'd3; i_wr_way = 2'd1;
    for (int b = 0; b < 4; b++) begin
      i_wr_data = 80'hD0 + 80'(b);
      step();
      if (b == 0) begin i_wr_set = 4'hF; i_wr_way = 2'd0; end
      chk("t2_addr", o_da_addr, 8'(8'h34 + b));
      chk("t2_we", o_da_we, 1);
      chk("t2_wdata", o_da_wdata, 80'hD0 + 80'(b));
      chk("t2_busy", o_busy, (b != 3));
      chk("t2_done", o_wr_done, (b == 3));
    end
    i_wr_valid = 0;
    step();
    chk("t2_after_valid", o_da_valid, 0);
    chk("t2_after_done", o_wr_done, 0);

    // Contention: read held against three back-to-back blocks
    i_rd_valid = 1; i_rd_set = 4'd9; i_rd_way = 2'd3; i_rd_word = 2'd2;
    i_wr_valid = 1; i_wr_set = 4'd1; i_wr_way = 2'd0; i_wr_data = 80'hC0FFEE;
    rd_cyc = -1; ndone = 0;
    for (int c = 0; c < 40 && ndone < 3; c++) begin
      #1;
      if (o_rd_ready && rd_cyc < 0) rd_cyc = c;
      step();
      if (o_wr_done) ndone++;
      if (rd_cyc >= 0) i_rd_valid = 0;
    end
    i_wr_valid = 0;
    chk("t3_rd_cycle", 128'(rd_cyc), 128'(4));
    chk("t3_blocks", 128'(ndone), 128'(3));
    step();

    // Halt for two cycles during beat 2
    i_wr_valid = 1; i_wr_set = 4'd6; i_wr_way = 2'd2;
    i_wr_data = 80'hA0; step();
    i_wr_data = 80'hA1; step();
    chk("t4_beat1", o_da_addr, 8'h69);
    i_da_halt = 1; i_wr_data = 80'hA2;
    #1;
    chk("t4_halt_ready", o_wr_ready, 0);
    step();
    chk("t4_hold_addr", o_da_addr, 8'h69);
    chk("t4_hold_valid", o_da_valid, 1);
    step();
    chk("t4_hold_addr2", o_da_addr, 8'h69);
    chk("t4_hold_wdata", o_da_wdata, 80'hA1);
    i_da_halt = 0;
    step();
    chk("t4_beat2", o_da_addr, 8'h6A);
    chk("t4_beat2_data", o_da_wdata, 80'hA2);
    i_wr_data = 80'hA3; step();
    chk("t4_beat3", o_da_addr, 8'h6B);
    chk("t4_done", o_wr_done, 1);
    i_wr_valid = 0;
    step();

    // Write valid dropped mid-burst with a read pending
    i_wr_valid = 1; i_wr_set = 4'd12; i_wr_way = 2'd3;
    i_wr_data = 80'hB0; step();
    i_wr_data = 80'hB1; step();
    i_wr_valid = 0;
    i_rd_valid = 1; i_rd_set = 4'd12; i_rd_way = 2'd3; i_rd_word = 2'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_no_rd", o_rd_ready, 0);
      step();
      chk("t5_busy", o_busy, 1);
      chk("t5_no_cmd", o_da_valid, 0);
    end
    i_wr_valid = 1; i_wr_data = 80'hB2; step();
    chk("t5_beat2", o_da_addr, 8'hCE);
    i_wr_data = 80'hB3; step();
    chk("t5_beat3", o_da_addr, 8'hCF);
    chk("t5_done", o_wr_done, 1);
    i_wr_valid = 0;
    step();
    chk("t5_rd_after", o_da_addr, 8'hCF);
    chk("t5_rd_we", o_da_we, 0);
    i_rd_valid = 0;
    step();

    // Reset during beat 2, then a fresh block from beat 0
    i_wr_valid = 1; i_wr_set = 4'd2; i_wr_way = 2'd1; i_wr_data = 80'hE0;
    repeat (3) step();
    chk("t6_beat2", o_da_addr, 8'h26);
    #1 arst_n = 1'b0;
    #1;
    chk("t6_rst_valid", o_da_valid, 0);
    chk("t6_rst_addr", o_da_addr, 0);
    chk("t6_rst_wdata", o_da_wdata, 0);
    chk("t6_rst_busy", o_busy, 0);
    chk("t6_rst_wr_ready", o_wr_ready, 0);
    step();
    arst_n = 1'b1;
    step();
    chk("t6_restart", o_da_addr, 8'h24);
    chk("t6_restart_busy", o_busy, 1);
    repeat (3) step();
    chk("t6_done", o_wr_done, 1);
    i_wr_valid = 0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_array_arbiter.md
# icache_array_arbiter

Shares the single data-array SRAM port between the cache lookup pipeline (single-word reads) and the miss-path arrays updater (4-beat block writes of 80 bits each, 320-bit block). Writes have priority and hold the port for a whole block. A starvation counter guarantees reads forward progress between blocks. The block sits between the lookup/miss-handler logic and the data-array blocks interface, and registers one SRAM command per cycle.

## Interface
- SET_BITS_WIDTH, 4, set index width
- NUM_WAYS, 4, ways per set (way index = $clog2(NUM_WAYS) bits)
- DA_WRITE_WIDTH, 80, write beat width
- DA_BEATS, 4, beats per block write (beat index 2 bits)
- STARVE_LIMIT, 3, consecutive lost read cycles before a read wins
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- i_rd_valid  in  1  lookup read request
- i_rd_set  in  SET_BITS_WIDTH  read set
- i_rd_way  in  2  read way
- i_rd_word  in  2  read word-group (SRAM row within block)
- o_rd_ready  out  1  read accepted this cycle (combinational)
- i_wr_valid  in  1  block-write request (held for the whole block)
- i_wr_set  in  SET_BITS_WIDTH  write set (sampled at beat 0)
- i_wr_way  in  2  write way (sampled at beat 0)
- i_wr_data  in  DA_WRITE_WIDTH  current beat data
- o_wr_ready  out  1  beat accepted this cycle (combinational)
- o_wr_done  out  1  one-cycle pulse: last beat accepted
- i_da_halt  in  1  data-array port cannot accept a command
- o_da_valid  out  1  registered command valid
- o_da_we  out  1  1 = write, 0 = read
- o_da_addr  out  8  {set, way, beat/word}
- o_da_wdata  out  DA_WRITE_WIDTH  write data (0 on reads)
- o_busy  out  1  write burst in progress (state WR_BURST)

## Operation
- States: IDLE, WR_BURST. Internal: 2-bit beat counter, starve counter (saturating at STARVE_LIMIT), latched wr set/way.
- Accept condition: ready = grant & ~i_da_halt. Transfer = valid & ready. No request is accepted while i_da_halt = 1.
- IDLE grant:
  - If only one requester is valid, it wins.
  - If both are valid, the write wins unless starve == STARVE_LIMIT, in which case the read wins.
- Write accepted in IDLE: issue beat 0 using i_wr_set/i_wr_way, latch set/way, set beat = 1, and go to WR_BURST.
- WR_BURST: only writes are granted. Each accepted beat issues {latched set, latched way, beat}, then beat increments.
  - Accepting beat DA_BEATS-1 pulses o_wr_done, clears beat to 0, and returns to IDLE.
  - If i_wr_valid drops mid-burst, the block stalls in WR_BURST with no command issued. The burst is never abandoned except by reset.
- Starve counter:
  - Increments (saturating) each cycle i_rd_valid = 1 with no read transfer, in either state, including halt cycles.
  - Clears on read transfer.
  - Holds when i_rd_valid = 0.
- Read transfer: o_da_we = 0, o_da_addr = {i_rd_set, i_rd_way, i_rd_word}, o_da_wdata = 0.
- A read to the set being filled cannot be issued mid-block, because WR_BURST locks the port. This is the coherency rule.

## Timing
- Reset values: o_da_valid = 0, o_da_we = 0, o_da_addr = 0, o_da_wdata = 0, o_wr_done = 0, o_busy = 0. State is IDLE, beat = 0, starve = 0. o_rd_ready and o_wr_ready are 0 during reset.
- Latency: a transfer in cycle N produces the command on o_da_* in cycle N+1. o_wr_done is registered and asserts in cycle N+1 of the last beat.
- If i_da_halt = 1, the o_da_* registers hold their value, including o_da_valid.
- If i_da_halt = 0 and there is no transfer, o_da_valid = 0 on the next cycle.
- A full uncontended block takes 4 consecutive cycles. The first read after a contended block issues on the cycle after the last beat.
- Simultaneous read/write valid when starve == STARVE_LIMIT in IDLE: the read wins. The write waits one cycle, then takes the port.
- Reset mid-burst: returns to IDLE immediately. The updater must restart the block from beat 0.

## Test plan
- Single read: after reset, i_rd_valid with set 5, way 2, word 1 → o_rd_ready = 1; next cycle o_da_valid = 1, we = 0, addr = 0x59.
- Uncontended block write: set 3, way 1, data D0..D3 → addr 0x34, 0x35, 0x36, 0x37 on 4 consecutive cycles; o_busy high for beats 1–3; o_wr_done pulses with beat 3.
- Contention: read held valid while 3 blocks are requested back-to-back → after at most STARVE_LIMIT (3) lost cycles and a completed block, the read issues before the next block's beat 0; starve returns to 0.
- Halt: i_da_halt = 1 for 2 cycles during beat 2 → o_da_* frozen, o_wr_ready = 0, no beat skipped or duplicated; beat 3 follows release.
- Mid-burst valid drop: i_wr_valid low for 3 cycles after beat 1 with a read pending → no read granted, o_busy stays 1, burst resumes at beat 2.
- Reset during beat 2: all outputs go to 0 asynchronously; after release, a new write starts at beat 0.
